debounce_filter: RTL and testbench



---
 rtl/debounce_pkg.sv | 14 +
 rtl/sync_2ff.sv | 25 ++
 rtl/debounce_filter.sv | 134 +++++++++++++
 tb/tb_debounce_filter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and limits for the debounce filter.
// Used by debounce_filter under both settings of DEBOUNCE_SYNC_EN.
package debounce_pkg;

    localparam int unsigned DEBOUNCE_MIN_STABLE = 2;

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        WAIT_HI = 2'd1,
        HIGH    = 2'd2,
        WAIT_LO = 2'd3
    } debounce_state_e;

endpackage : debounce_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; resets to 0.
// Generic so other input stages can reuse it.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync_2ff

// File: rtl/debounce_filter.sv
// Debounce filter: optional input synchroniser (DEBOUNCE_SYNC_EN), 4-state
// stability FSM, registered level plus rise/fall/glitch pulses.
module debounce_filter
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall,
    output logic glitch
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (STABLE_CYCLES < DEBOUNCE_MIN_STABLE) begin : g_bad_stable_cycles
            $error("debounce_filter: STABLE_CYCLES must be at least 2");
        end
    endgenerate

    logic w_s;

`ifdef DEBOUNCE_SYNC_EN
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (w_s)
    );
`else
    assign w_s = din;
`endif

    debounce_state_e  r_state;
    debounce_state_e  w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_q;
    logic             w_q_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;
    logic             r_glitch;
    logic             w_glitch_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= LOW;
            r_cnt    <= '0;
            r_q      <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_q      <= w_q_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
            r_glitch <= w_glitch_nxt;
        end
    end

    // Counter restarts on every state change, so it never exceeds CNT_LAST.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_q_nxt      = r_q;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        w_glitch_nxt = 1'b0;

        case (r_state)
            LOW: begin
                if (w_s) begin
                    w_state_nxt = WAIT_HI;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!w_s) begin
                    w_state_nxt  = LOW;
                    w_cnt_nxt    = '0;
                    w_glitch_nxt = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = '0;
                    w_q_nxt     = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (!w_s) begin
                    w_state_nxt = WAIT_LO;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (w_s) begin
                    w_state_nxt  = HIGH;
                    w_cnt_nxt    = '0;
                    w_glitch_nxt = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = '0;
                    w_q_nxt     = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = LOW;
                w_cnt_nxt   = '0;
                w_q_nxt     = 1'b0;
            end
        endcase
    end

    assign q      = r_q;
    assign rise   = r_rise;
    assign fall   = r_fall;
    assign glitch = r_glitch;

endmodule : debounce_filter

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter: two instances (STABLE_CYCLES 4 and 2)
// share one din; expected edge indices are hand-derived from the latency rules.
module tb_debounce_filter;

`ifdef DEBOUNCE_SYNC_EN
    localparam int OFF = 2;
`else
    localparam int OFF = 0;
`endif
    localparam int SC = 4;
    localparam int L  = SC - 1 + OFF;
    localparam int L2 = 2 - 1 + OFF;

    logic clk;
    logic rst;
    logic din;
    logic q, rise, fall, glitch;
    logic q2, rise2, fall2, glitch2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    debounce_filter #(.STABLE_CYCLES(SC)) dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .q      (q),
        .rise   (rise),
        .fall   (fall),
        .glitch (glitch)
    );

    debounce_filter #(.STABLE_CYCLES(2)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .q      (q2),
        .rise   (rise2),
        .fall   (fall2),
        .glitch (glitch2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Per-window statistics, index 0 = dut, 1 = dut2. k* hold the cycle index or -1.
    int nr[2], nf[2], ng[2], nmulti[2];
    int kr[2], kf[2], kg[2], kq[2];
    logic qstart[2];
    logic qlast[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic void acc(input int i, input logic qq, input logic rr,
                                input logic ff, input logic gg, input int j);
        if (rr === 1'b1) begin nr[i]++; kr[i] = j; end
        if (ff === 1'b1) begin nf[i]++; kf[i] = j; end
        if (gg === 1'b1) begin ng[i]++; kg[i] = j; end
        if ((int'(rr === 1'b1) + int'(ff === 1'b1) + int'(gg === 1'b1)) > 1) nmulti[i]++;
        if ((qq !== qstart[i]) && (kq[i] < 0)) kq[i] = j;
        qlast[i] = qq;
    endfunction

    // Drive pat[0..plen-1] then hold; din applied in iteration j is captured at edge E_j.
    task automatic run(input logic [15:0] pat, input int plen, input logic hold, input int n);
        qstart[0] = q;
        qstart[1] = q2;
        for (int i = 0; i < 2; i++) begin
            nr[i] = 0; nf[i] = 0; ng[i] = 0; nmulti[i] = 0;
            kr[i] = -1; kf[i] = -1; kg[i] = -1; kq[i] = -1;
        end
        for (int j = 0; j < n; j++) begin
            din = (j < plen) ? pat[j] : hold;
            @(posedge clk);
            #1;
            acc(0, q, rise, fall, glitch, j);
            acc(1, q2, rise2, fall2, glitch2, j);
        end
    endtask

    task automatic do_reset(input string tag, input logic d);
        din = d;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " q"},      32'(q),      32'd0);
        chk({tag, " rise"},   32'(rise),   32'd0);
        chk({tag, " fall"},   32'(fall),   32'd0);
        chk({tag, " glitch"}, 32'(glitch), 32'd0);
        chk({tag, " q2"},     32'(q2),     32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b0;
        do_reset("reset", 1'b0);

        // Bounce reject: two-cycle high pulse
        run(16'b11, 2, 1'b0, 10);
        chk("rej glitch count", 32'(ng[0]), 32'd1);
        chk("rej glitch cycle", 32'(kg[0]), 32'(OFF + 2));
        chk("rej rise count",   32'(nr[0]), 32'd0);
        chk("rej q change",     32'(kq[0]), 32'(-1));

        // Bounce then settle: 1,0,1 then held 1
        run(16'b101, 3, 1'b1, 14);
        chk("settle glitch count", 32'(ng[0]), 32'd1);
        chk("settle glitch cycle", 32'(kg[0]), 32'(OFF + 1));
        chk("settle rise count",   32'(nr[0]), 32'd1);
        chk("settle rise cycle",   32'(kr[0]), 32'(OFF + 5));
        chk("settle q end",        32'(qlast[0]), 32'd1);
        chk("settle exclusive",    32'(nmulti[0]), 32'd0);

        // Falling edge held low
        run(16'b0, 0, 1'b0, 12);
        chk("fall count",   32'(nf[0]), 32'd1);
        chk("fall cycle",   32'(kf[0]), 32'(L));
        chk("fall q cycle", 32'(kq[0]), 32'(L));
        chk("fall glitch",  32'(ng[0]), 32'd0);
        chk("fall q end",   32'(qlast[0]), 32'd0);

        // Clean rising step
        run(16'b0, 0, 1'b1, 12);
        chk("step rise count", 32'(nr[0]), 32'd1);
        chk("step rise cycle", 32'(kr[0]), 32'(L));
        chk("step q cycle",    32'(kq[0]), 32'(L));
        chk("step glitch",     32'(ng[0]), 32'd0);
        chk("step fall",       32'(nf[0]), 32'd0);
        chk("step q end",      32'(qlast[0]), 32'd1);

        // Three-cycle low dip from high
        run(16'b0, 3, 1'b1, 12);
        chk("dip glitch count", 32'(ng[0]), 32'd1);
        chk("dip glitch cycle", 32'(kg[0]), 32'(OFF + 3));
        chk("dip fall count",   32'(nf[0]), 32'd0);
        chk("dip q change",     32'(kq[0]), 32'(-1));
        chk("dip exclusive",    32'(nmulti[0]), 32'd0);

        // Reset while HIGH drops the level without a fall pulse
        do_reset("rst high", 1'b0);
        run(16'b0, 0, 1'b0, 8);
        chk("post rst pulses", 32'(nr[0] + nf[0] + ng[0]), 32'd0);
        chk("post rst q",      32'(qlast[0]), 32'd0);

        // Reset in WAIT_HI with cnt=2, din held high through reset
        run(16'b0, 0, 1'b1, OFF + 2);
        chk("wait_hi q", 32'(kq[0]), 32'(-1));
        do_reset("rst wait_hi", 1'b1);
        run(16'b0, 0, 1'b1, 12);
        chk("rehi rise count", 32'(nr[0]), 32'd1);
        chk("rehi rise cycle", 32'(kr[0]), 32'(L));
        chk("rehi glitch",     32'(ng[0]), 32'd0);

        // STABLE_CYCLES=2 instance
        do_reset("rst sc2", 1'b0);
        run(16'b0, 0, 1'b1, 8);
        chk("sc2 rise count", 32'(nr[1]), 32'd1);
        chk("sc2 rise cycle", 32'(kr[1]), 32'(L2));
        chk("sc2 glitch",     32'(ng[1]), 32'd0);
        run(16'b0, 0, 1'b0, 8);
        chk("sc2 fall cycle", 32'(kf[1]), 32'(L2));
        chk("sc2 q end",      32'(qlast[1]), 32'd0);
        run(16'b1, 1, 1'b0, 8);
        chk("sc2 glitch count", 32'(ng[1]), 32'd1);
        chk("sc2 glitch cycle", 32'(kg[1]), 32'(OFF + 1));
        chk("sc2 q change",     32'(kq[1]), 32'(-1));
        chk("sc2 exclusive",    32'(nmulti[1]), 32'd0);
        chk("sc4 pulse glitch", 32'(kg[0]), 32'(OFF + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_debounce_filter
